// File: rtl/pe2ddr_pkg.sv
// Shared constants and types for the PE->DDR write path: word geometry,
// burst limits, write-controller state encoding and the burst command record.
package pe2ddr_pkg;

  localparam int DDR_W      = 512;
  localparam int DDR_BYTES  = DDR_W / 8;
  localparam int BYTE_SHIFT = $clog2(DDR_BYTES);
  localparam int ADDR_W     = 32;
  localparam int BURST_LEN  = 16;
  localparam int FIFO_DEPTH = 32;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    RESP
  } wr_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
  } wr_cmd_t;

endpackage

// File: rtl/pe_ddr_wr_ctrl_if.sv
// Bus bundle between the data generator, the write controller and the DDR write port.
// master = controller side, slave = generator/DDR side.
interface pe_ddr_wr_ctrl_if #(
  parameter int DDR_W  = pe2ddr_pkg::DDR_W,
  parameter int ADDR_W = pe2ddr_pkg::ADDR_W
);

  logic [DDR_W-1:0]  s_data;
  logic              s_valid;
  logic              s_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DDR_W-1:0]  wr_data;
  logic              wr_last;
  logic              wr_valid;
  logic              wr_ready;
  logic              resp_valid;

  modport master (
    input  s_data, s_valid, cmd_ready, wr_ready, resp_valid,
    output s_ready, cmd_addr, cmd_len, cmd_valid, wr_data, wr_last, wr_valid
  );

  modport slave (
    output s_data, s_valid, cmd_ready, wr_ready, resp_valid,
    input  s_ready, cmd_addr, cmd_len, cmd_valid, wr_data, wr_last, wr_valid
  );

endinterface

// File: rtl/pe_ddr_wr_ctrl_sync_fifo.sv
// Show-ahead synchronous FIFO: dout_o is the head word whenever empty_o is low.
// Pushes at full and pops at empty are dropped.
module sync_fifo #(
  parameter int DW    = 512,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [DW-1:0]            din_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q;
  logic           push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // NOTE: the storage array has no reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  // NOTE: registers use <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pe_ddr_wr_ctrl.sv
// Buffers the generator result stream and issues DDR burst commands plus write beats.
// Define DDR_WR_4K_SPLIT_EN to cap bursts so none crosses a 4 KB address boundary.
module pe_ddr_wr_ctrl
  import pe2ddr_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  output logic               done_o,
  input  logic [ADDR_W-1:0]  conf_base_addr_i,
  input  logic [15:0]        conf_word_num_i,
  pe_ddr_wr_ctrl_if.master   bus_if
);

  wr_state_e                  state_q, state_d;
  logic [CNT_W-1:0]           words_rem_q, words_rem_d;
  logic [CNT_W-1:0]           cur_len_q, cur_len_d;
  logic [CNT_W-1:0]           beat_q, beat_d;
  logic [CNT_W-1:0]           burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0]           resp_cnt_q, resp_cnt_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [CNT_W-1:0]           len;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                       fifo_full, fifo_empty, push, pop, s_ready;
  logic                       cmd_valid, wr_valid, wr_last;
  logic [DDR_W-1:0]           fifo_head;
  wr_cmd_t                    cmd;

`ifdef DDR_WR_4K_SPLIT_EN
  logic [12:0]      room_bytes;
  logic [CNT_W-1:0] room_words;
  assign room_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
  assign room_words = CNT_W'(room_bytes >> BYTE_SHIFT);
`endif

  always_comb begin
    len = (words_rem_q < CNT_W'(BURST_LEN)) ? words_rem_q : CNT_W'(BURST_LEN);
`ifdef DDR_WR_4K_SPLIT_EN
    if (room_words < len) len = room_words;
`endif
  end

  assign s_ready = !fifo_full && (state_q != IDLE);
  assign push    = bus_if.s_valid && s_ready;
  assign done_o  = (state_q == IDLE);

  sync_fifo #(.DW(DDR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (bus_if.s_data),
    .pop_i   (pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    words_rem_d = words_rem_q;
    cur_len_d   = cur_len_q;
    beat_d      = beat_q;
    burst_cnt_d = burst_cnt_q;
    addr_d      = addr_q;
    resp_cnt_d  = resp_cnt_q;
    cmd_valid   = 1'b0;
    wr_valid    = 1'b0;
    wr_last     = 1'b0;
    pop         = 1'b0;
    if (state_q != IDLE && bus_if.resp_valid) resp_cnt_d = resp_cnt_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (start_i && conf_word_num_i != '0) begin
          state_d     = CMD;
          words_rem_d = conf_word_num_i;
          addr_d      = conf_base_addr_i;
          burst_cnt_d = '0;
          resp_cnt_d  = '0;
        end
      end
      CMD: begin
        // Whole burst must already be buffered so the data phase never starves.
        cmd_valid = (CNT_W'(fifo_count) >= len);
        if (cmd_valid && bus_if.cmd_ready) begin
          state_d     = DATA;
          cur_len_d   = len;
          beat_d      = '0;
          addr_d      = addr_q + (ADDR_W'(len) << BYTE_SHIFT);
          words_rem_d = words_rem_q - len;
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        wr_valid = !fifo_empty;
        wr_last  = wr_valid && (beat_q == cur_len_q - CNT_W'(1));
        if (wr_valid && bus_if.wr_ready) begin
          pop    = 1'b1;
          beat_d = beat_q + CNT_W'(1);
          if (wr_last) begin
            if (words_rem_q != '0)              state_d = CMD;
            else if (resp_cnt_d == burst_cnt_q) state_d = IDLE;
            else                                state_d = RESP;
          end
        end
      end
      RESP: begin
        if (resp_cnt_d == burst_cnt_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      words_rem_q <= '0;
      cur_len_q   <= '0;
      beat_q      <= '0;
      burst_cnt_q <= '0;
      resp_cnt_q  <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      words_rem_q <= words_rem_d;
      cur_len_q   <= cur_len_d;
      beat_q      <= beat_d;
      burst_cnt_q <= burst_cnt_d;
      resp_cnt_q  <= resp_cnt_d;
      addr_q      <= addr_d;
    end
  end

  assign cmd.addr         = addr_q;
  assign cmd.len          = 8'(len - CNT_W'(1));
  assign bus_if.s_ready   = s_ready;
  assign bus_if.cmd_addr  = cmd.addr;
  assign bus_if.cmd_len   = cmd.len;
  assign bus_if.cmd_valid = cmd_valid;
  assign bus_if.wr_data   = fifo_head;
  assign bus_if.wr_last   = wr_last;
  assign bus_if.wr_valid  = wr_valid;

endmodule
